alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter MUL_LAT, default 2, ALU settle cycles for multiply (legal range 1-15).
REQ-002 Parameter DIV_LAT, default 8, ALU settle cycles for divide (legal range 1-15).
REQ-003 Parameter BASE_LAT, default 1, settle cycles for ADD/SUB/AND/OR (legal range 1-15).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  1  request present; req_ready  output  1  block can accept.
REQ-007 req_aluop  input  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
REQ-008 req_funct3  input  3; req_funct7  input  7  R-type function fields.
REQ-009 req_a, req_b  input  64 each  operands.
REQ-010 alu_in1, alu_in2  output  64 each; alu_ctrl  output  4  drive to ALU_Top.
REQ-011 alu_result  input  64; alu_zero  input  1; alu_ovf  input  1  ALU_Top outputs.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_result  output  64; rsp_zero, rsp_ovf, rsp_illegal  output  1 each.

Function
REQ-014 ALU_ctrl encodings: AND 0000, OR 0001, ADD 0010, DIV 0011, SUB 0110, MUL 0111, NOP 1111.
REQ-015 Decode: aluop 00 -> ADD; 01 -> SUB; 10 with (funct7,funct3) = (0000000,000) ADD, (0100000,000) SUB, (0000001,000) MUL, (0000001,100) DIV, (0000000,111) AND, (0000000,110) OR.
REQ-016 Any other aluop 10 combination, and aluop 11, is illegal.
REQ-017 FSM states IDLE, EXEC, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE, req_valid=1 at an edge: register req_a->alu_in1, req_b->alu_in2, decoded ctrl->alu_ctrl, load countdown with (op latency - 1), go EXEC.
REQ-019 IDLE, req_valid=1 with illegal decode: alu_ctrl stays 1111, rsp_result=0, rsp_zero=0, rsp_ovf=0, rsp_illegal=1, go directly to RESP.
REQ-020 EXEC: count reaches 0 at an edge -> capture alu_result/alu_zero/alu_ovf into rsp_*, rsp_illegal=0, go RESP; otherwise decrement.
REQ-021 Latency: rsp_valid rises exactly L cycles after acceptance edge (L = BASE_LAT, MUL_LAT or DIV_LAT); illegal request: 1 cycle.
REQ-022 alu_in1/alu_in2/alu_ctrl stable through EXEC; alu_ctrl returns to 1111 on EXEC->RESP transition.
REQ-023 RESP: rsp_valid=1, rsp_* held stable until edge with rsp_ready=1, then IDLE with rsp_valid=0.
REQ-024 No new request is accepted in the same cycle a response is consumed (req_ready rises the cycle after handshake).
REQ-025 rsp_ready ignored outside RESP; req_valid ignored outside IDLE (no internal queue).
REQ-026 Operands passed unmodified, full 64 bits; no sign/width conversion in this block.

Reset
REQ-027 rst=1 forces immediately, independent of clk: state IDLE, req_ready=1 after deassertion, rsp_valid=0, alu_ctrl=1111, alu_in1=alu_in2=0, rsp_result=0, rsp_zero=rsp_ovf=rsp_illegal=0, countdown=0.
REQ-028 rst asserted mid-EXEC or mid-RESP abandons the operation; no response is produced for it.

Verification
REQ-029 ADD: aluop 10, funct (0000000,000), a=6, b=2 -> alu_ctrl 0010 one cycle, rsp_valid 1 cycle after accept, rsp_result=8, zero=0, ovf=0.
REQ-030 DIV: aluop 10, funct (0000001,100), a=6, b=2, DIV_LAT=8 -> alu_ctrl 0011 for 8 cycles, rsp_result=3 exactly 8 cycles after accept.
REQ-031 Zero flag: aluop 00, a=2, b=-2 -> alu_ctrl 0010, rsp_result=0, rsp_zero=1.
REQ-032 Illegal: aluop 11 -> alu_ctrl never leaves 1111, rsp_valid next cycle, rsp_illegal=1, rsp_result=0.
REQ-033 Backpressure: MUL a=6, b=2 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=12 held, req_ready=0, second req_valid not accepted until cycle after handshake.
REQ-034 Reset mid-op: assert rst during DIV EXEC cycle 3 -> outputs at reset values without a clock edge; no rsp_valid afterward.

Source files
------------

// File: rtl/alu_issue.sv
// ALU issue stage: decodes a request, drives ALU_Top for the op's settle time,
// then holds the captured result on a valid/ready response channel.
module alu_issue #(
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 8,
    parameter int unsigned BASE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_aluop,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [63:0] alu_in1,
    output logic [63:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_illegal
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_DIV = 4'b0011;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_MUL = 4'b0111;
    localparam logic [3:0] CTRL_NOP = 4'b1111;

    // Countdown preloads are latency minus one: the capture edge is the last of L edges.
    localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);
    localparam logic [3:0] BASE_CNT = 4'(BASE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic [63:0] alu_in1_q;
    logic [63:0] alu_in2_q;
    logic [3:0]  alu_ctrl_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_ovf_q;
    logic        rsp_illegal_q;

    logic [3:0]  dec_ctrl_s;
    logic        dec_illegal_s;
    logic [3:0]  dec_cnt_s;

    // Request decode: aluop/funct fields to ALU control code, legality and settle count.
    always_comb begin
        dec_ctrl_s    = CTRL_NOP;
        dec_illegal_s = 1'b0;
        case (req_aluop)
            2'b00: dec_ctrl_s = CTRL_ADD;
            2'b01: dec_ctrl_s = CTRL_SUB;
            2'b10: begin
                case ({req_funct7, req_funct3})
                    {7'b0000000, 3'b000}: dec_ctrl_s = CTRL_ADD;
                    {7'b0100000, 3'b000}: dec_ctrl_s = CTRL_SUB;
                    {7'b0000001, 3'b000}: dec_ctrl_s = CTRL_MUL;
                    {7'b0000001, 3'b100}: dec_ctrl_s = CTRL_DIV;
                    {7'b0000000, 3'b111}: dec_ctrl_s = CTRL_AND;
                    {7'b0000000, 3'b110}: dec_ctrl_s = CTRL_OR;
                    default:              dec_illegal_s = 1'b1;
                endcase
            end
            default: dec_illegal_s = 1'b1;
        endcase
        case (dec_ctrl_s)
            CTRL_MUL: dec_cnt_s = MUL_CNT;
            CTRL_DIV: dec_cnt_s = DIV_CNT;
            default:  dec_cnt_s = BASE_CNT;
        endcase
    end

    // Issue FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            req_ready_q   <= 1'b1;
            alu_in1_q     <= 64'd0;
            alu_in2_q     <= 64'd0;
            alu_ctrl_q    <= CTRL_NOP;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 64'd0;
            rsp_zero_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        alu_in1_q   <= req_a;
                        alu_in2_q   <= req_b;
                        req_ready_q <= 1'b0;
                        if (dec_illegal_s) begin
                            alu_ctrl_q    <= CTRL_NOP;
                            rsp_result_q  <= 64'd0;
                            rsp_zero_q    <= 1'b0;
                            rsp_ovf_q     <= 1'b0;
                            rsp_illegal_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            alu_ctrl_q <= dec_ctrl_s;
                            cnt_q      <= dec_cnt_s;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_result_q  <= alu_result;
                        rsp_zero_q    <= alu_zero;
                        rsp_ovf_q     <= alu_ovf;
                        rsp_illegal_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        alu_ctrl_q    <= CTRL_NOP;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready rises only after the handshake edge, so no same-cycle accept.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    alu_ctrl_q  <= CTRL_NOP;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
